load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit for the RV32 core. It takes one load or store per handshake, drives the data-memory request/grant/response port, and formats load data. For stores it aligns store data and generates byte enables. It delivers sign- or zero-extended `mem_data`, which is the memory operand of the writeback stage's ALU/memory select. One transaction is outstanding at a time; `busy` stalls the pipeline.

## Interface
- WIDTH, 32 (from `all_pkgs`), datapath width; block is specified for 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline presents a memory operation
- req_ready  out  1  unit can accept (high only in IDLE)
- mem_read  in  1  load request
- mem_write  in  1  store request
- funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  WIDTH  byte address
- store_data  in  WIDTH  rs2 value
- busy  out  1  transaction in flight (state != IDLE)
- resp_valid  out  1  one-cycle completion pulse
- mem_data  out  WIDTH  formatted load data, valid with resp_valid
- fault  out  1  misaligned or illegal funct3, valid with resp_valid
- dmem_req  out  1  memory request, held until dmem_gnt
- dmem_we  out  1  1 = write
- dmem_addr  out  WIDTH  word address, addr with [1:0] forced to 00
- dmem_be  out  4  byte enables
- dmem_wdata  out  WIDTH  lane-aligned store data
- dmem_gnt  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  WIDTH  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `req_ready`=1. On req_valid, capture addr, funct3, mem_read, mem_write and store_data.
  - Fault: funct3 in {011,110,111}; or H/HU with addr[0]=1; or W with addr[1:0]!=00; or mem_read and mem_write both 1. On fault, go to DONE with fault=1 and no dmem access.
  - Neither mem_read nor mem_write set: go to DONE with mem_data=0 and fault=0.
  - Otherwise go to REQ.
- REQ: dmem_req=1; address, we, be and wdata are stable. On dmem_gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on dmem_rvalid, register the formatted load data and go to DONE. dmem_rvalid is ignored in every other state.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Store lanes, with o=addr[1:0]:
  - SB: be=0001<<o, wdata={4{sd[7:0]}}.
  - SH: be=0011<<o, wdata={2{sd[15:0]}}.
  - SW: be=1111, wdata=sd.
- Loads select byte `rdata[8*o+:8]` or half `rdata[8*o+:16]`.
  - B and H sign-extend from bit 7 / bit 15.
  - BU and HU zero-extend.
  - W passes the word through.
- For loads, dmem_be reflects the access size, same formula as stores.
- mem_data and fault hold their value until the next DONE. They are meaningful only with resp_valid.

## Timing
- Reset (asynchronous, immediate): state=IDLE, req_ready=1, busy=0, resp_valid=0, fault=0, mem_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0.
- Reset mid-transaction: drop dmem_req immediately and discard the operation; a late dmem_rvalid is ignored.
- All dmem outputs are registered. Address, we, be and wdata are stable from entering REQ until gnt.
- Accept in cycle 0:
  - dmem_req asserts in cycle 1.
  - With gnt in cycle 1, a store has resp_valid in cycle 2.
  - A load with rvalid in cycle 2 has resp_valid in cycle 3.
  - Each cycle of gnt or rvalid delay adds one cycle.
- Fault or no-op: resp_valid in cycle 1.
- Next acceptance is earliest the cycle after DONE, giving a minimum of 2 cycles between requests.
- busy=1 in REQ, WAIT and DONE.

## Test plan
- Reset mid-operation: assert rst while in WAIT, then pulse dmem_rvalid -> no resp_valid; state IDLE with req_ready=1.
- Byte loads, with dmem_rdata=0x80FF7F01, gnt immediate and rvalid next cycle:
  - LB at addr 0x1003 -> resp_valid in cycle 3, mem_data=0xFFFFFF80, dmem_addr=0x1000, be=1000.
  - LBU at addr 0x1003 -> mem_data=0x00000080.
- Half loads on the same rdata:
  - LH at addr 0x1002 -> mem_data=0xFFFF80FF.
  - LHU at addr 0x1000 -> mem_data=0x00007F01.
  - LW at addr 0x1000 -> mem_data=0x80FF7F01.
- Stores:
  - SB of 0x12345678 at addr 0x2001 -> be=0010, wdata=0x78787878, we=1.
  - SH at addr 0x2002 -> be=1100, wdata=0x56785678.
  - With gnt delayed 3 cycles, dmem_req is held steady and resp_valid comes 1 cycle after gnt.
- Faults:
  - LW at 0x2002 -> resp_valid in cycle 1, fault=1, dmem_req never asserts.
  - funct3=011 -> fault=1.
  - SH at 0x2001 -> fault=1.
- Stray response: rvalid pulsed in IDLE and in REQ -> ignored; back-to-back requests accepted no sooner than 2 cycles apart.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory request/grant/response signals of the load/store unit.
// The unit takes the slave modport; the pipeline/memory environment takes the master modport.
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             mem_read;
    logic             mem_write;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] store_data;
    logic             busy;
    logic             resp_valid;
    logic [WIDTH-1:0] mem_data;
    logic             fault;
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [3:0]       dmem_be;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_gnt;
    logic             dmem_rvalid;
    logic [WIDTH-1:0] dmem_rdata;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, store_data,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output req_ready, busy, resp_valid, mem_data, fault,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, store_data,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  req_ready, busy, resp_valid, mem_data, fault,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 memory-stage load/store unit: one op outstanding; store resp 2 cycles after accept, load 3, fault/no-op 1, +1 per gnt/rvalid stall.
// Backpressure: req_ready only in IDLE, busy stalls the pipeline; dmem_req held with stable address/be/wdata until dmem_gnt.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic             dmem_we_q, dmem_we_d;
    logic [WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic [WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] mem_data_q, mem_data_d;
    logic             fault_q, fault_d;

    logic             req_fault;
    logic [3:0]       req_be;
    logic [WIDTH-1:0] req_wdata;
    logic [WIDTH-1:0] rdata_sh;
    logic [WIDTH-1:0] load_fmt;

    // Request decode on the incoming operation, and load formatting on the captured size/offset.
    always_comb begin
        req_fault = 1'b0;
        case (bus.funct3)
            3'b011, 3'b110, 3'b111: req_fault = 1'b1;
            3'b001, 3'b101:         req_fault = bus.addr[0];
            3'b010:                 req_fault = (bus.addr[1:0] != 2'b00);
            default:                req_fault = 1'b0;
        endcase
        if (bus.mem_read && bus.mem_write) req_fault = 1'b1;

        case (bus.funct3[1:0])
            2'b00:   begin req_be = 4'b0001 << bus.addr[1:0]; req_wdata = {4{bus.store_data[7:0]}};  end
            2'b01:   begin req_be = 4'b0011 << bus.addr[1:0]; req_wdata = {2{bus.store_data[15:0]}}; end
            default: begin req_be = 4'b1111;                  req_wdata = bus.store_data;            end
        endcase

        rdata_sh = bus.dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b100:  load_fmt = {24'd0, rdata_sh[7:0]};
            3'b001:  load_fmt = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b101:  load_fmt = {16'd0, rdata_sh[15:0]};
            default: load_fmt = rdata_sh;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        mem_data_d   = mem_data_q;
        fault_d      = fault_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_fault || !(bus.mem_read || bus.mem_write)) begin
                        state_d    = DONE;
                        fault_d    = req_fault;
                        mem_data_d = '0;
                    end else begin
                        state_d      = REQ;
                        dmem_we_d    = bus.mem_write;
                        dmem_addr_d  = {bus.addr[WIDTH-1:2], 2'b00};
                        dmem_be_d    = req_be;
                        dmem_wdata_d = req_wdata;
                        off_d        = bus.addr[1:0];
                        funct3_d     = bus.funct3;
                    end
                end
            end
            REQ: begin
                if (bus.dmem_gnt) begin
                    if (dmem_we_q) begin
                        state_d    = DONE;
                        fault_d    = 1'b0;
                        mem_data_d = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.dmem_rvalid) begin
                    state_d    = DONE;
                    fault_d    = 1'b0;
                    mem_data_d = load_fmt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= '0;
            off_q        <= 2'b00;
            funct3_q     <= 3'b000;
            mem_data_q   <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            mem_data_q   <= mem_data_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.dmem_req   = (state_q == REQ);
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.fault      = fault_q;
endmodule
